rsff_inst: RTL and testbench



---
 rtl/rsff_pkg.sv | 34 +++
 rtl/rsff_inst_bit.sv | 37 +++
 rtl/rsff_inst.sv | 49 ++++
 tb/tb_rsff_inst.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsff_pkg.sv
// rsff_pkg: shared definitions for the clocked RS flip-flop bank.
//   - RSFF_* constants select what a bit does when S and R are both requested.
//   - rsff_next() is the single next-state rule used by every flop.
package rsff_pkg;

  // S=R=1 policies
  localparam int RSFF_HOLD      = 0;  // keep current value
  localparam int RSFF_RESET_DOM = 1;  // clear wins
  localparam int RSFF_SET_DOM   = 2;  // set wins
  localparam int RSFF_TOGGLE    = 3;  // invert current value

  // Next value of one RS bit given its current value, the sampled set/reset
  // requests and the S=R=1 policy.
  function automatic logic rsff_next(input logic q, input logic s,
                                     input logic r, input int mode);
    logic nq;
    nq = q;
    unique case ({s, r})
      2'b00: nq = q;
      2'b10: nq = 1'b1;
      2'b01: nq = 1'b0;
      default: begin
        unique case (mode)
          RSFF_HOLD:      nq = q;
          RSFF_RESET_DOM: nq = 1'b0;
          RSFF_SET_DOM:   nq = 1'b1;
          default:        nq = ~q;
        endcase
      end
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/rsff_inst_bit.sv
// rsff_bit: one synchronous RS flip-flop with a registered conflict flag.
//   clk      rising-edge clock
//   rst      synchronous active-high reset, loads RST_BIT and clears conflict
//   s, r     set / reset requests, sampled only at the rising edge
//   q        registered state
//   conflict 1 for one cycle after an edge that sampled s=r=1
// S/R are level requests with no handshake: whatever is present at the edge
// is acted on, and nothing between edges matters.
module rsff_bit
  import rsff_pkg::*;
#(
  parameter int   BOTH_MODE = RSFF_RESET_DOM,
  parameter logic RST_BIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q,
  output logic conflict
);

  if (BOTH_MODE < RSFF_HOLD || BOTH_MODE > RSFF_TOGGLE) begin : g_bad_mode
    $error("rsff_bit: BOTH_MODE must be 0..3, got %0d", BOTH_MODE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= RST_BIT;
      conflict <= 1'b0;
    end else begin
      q        <= rsff_next(q, s, r, BOTH_MODE);
      conflict <= s & r;
    end
  end

endmodule

// File: rtl/rsff_inst.sv
// rsff_inst: bank of WIDTH independent clocked RS flip-flops.
//   clk       rising-edge clock
//   rst       synchronous active-high reset (Q <= RST_VAL, conflict <= 0)
//   R, S      per-bit reset / set requests
//   Q         registered state
//   Qn        ~Q, decoded from the Q register only (no path from S/R)
//   conflict  registered per-bit S=R=1 indication from the last edge
// Parameters: WIDTH (>=1), BOTH_MODE (0 hold, 1 reset-dom, 2 set-dom,
// 3 toggle), RST_VAL (reset value of Q).
module rsff_inst
  import rsff_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               BOTH_MODE = RSFF_RESET_DOM,
  parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] R,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic [WIDTH-1:0] conflict
);

  if (WIDTH < 1) begin : g_bad_width
    $error("rsff_inst: WIDTH must be >= 1, got %0d", WIDTH);
  end
  if (BOTH_MODE < RSFF_HOLD || BOTH_MODE > RSFF_TOGGLE) begin : g_bad_mode
    $error("rsff_inst: BOTH_MODE must be 0..3, got %0d", BOTH_MODE);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    rsff_bit #(
      .BOTH_MODE (BOTH_MODE),
      .RST_BIT   (RST_VAL[i])
    ) u_bit (
      .clk      (clk),
      .rst      (rst),
      .s        (S[i]),
      .r        (R[i]),
      .q        (Q[i]),
      .conflict (conflict[i])
    );
  end

  assign Qn = ~Q;

endmodule

// File: tb/tb_rsff_inst.sv
// tb_rsff_inst: drives five rsff_inst instances (modes 0..3 with RST_VAL=0,
// plus mode 3 with RST_VAL=0110) from shared stimulus and compares every
// output against a whole-vector reference model after each edge.
module tb_rsff_inst;
  import rsff_pkg::*;

  localparam int NI = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_r = '0;
  logic [3:0] req_s = '0;

  logic [3:0] q_o  [NI];
  logic [3:0] qn_o [NI];
  logic [3:0] cf_o [NI];

  int         mode_m [NI] = '{0, 1, 2, 3, 3};
  logic [3:0] rstv_m [NI] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0110};
  logic [3:0] q_m    [NI];
  logic [3:0] cf_m   [NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rsff_inst #(.WIDTH(4), .BOTH_MODE(0), .RST_VAL(4'b0000)) u_m0 (
    .clk(clk), .rst(rst), .R(req_r), .S(req_s), .Q(q_o[0]), .Qn(qn_o[0]), .conflict(cf_o[0]));
  rsff_inst #(.WIDTH(4), .BOTH_MODE(1), .RST_VAL(4'b0000)) u_m1 (
    .clk(clk), .rst(rst), .R(req_r), .S(req_s), .Q(q_o[1]), .Qn(qn_o[1]), .conflict(cf_o[1]));
  rsff_inst #(.WIDTH(4), .BOTH_MODE(2), .RST_VAL(4'b0000)) u_m2 (
    .clk(clk), .rst(rst), .R(req_r), .S(req_s), .Q(q_o[2]), .Qn(qn_o[2]), .conflict(cf_o[2]));
  rsff_inst #(.WIDTH(4), .BOTH_MODE(3), .RST_VAL(4'b0000)) u_m3 (
    .clk(clk), .rst(rst), .R(req_r), .S(req_s), .Q(q_o[3]), .Qn(qn_o[3]), .conflict(cf_o[3]));
  rsff_inst #(.WIDTH(4), .BOTH_MODE(3), .RST_VAL(4'b0110)) u_m3r (
    .clk(clk), .rst(rst), .R(req_r), .S(req_s), .Q(q_o[4]), .Qn(qn_o[4]), .conflict(cf_o[4]));

  // Reference model: whole-vector rule. Lone set ORs in, lone reset masks
  // out, and bits with both requests take the policy vector for the mode.
  task automatic model_edge();
    logic [3:0] both, base, pol;
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        q_m[k]  = rstv_m[k];
        cf_m[k] = 4'b0000;
      end else begin
        both = req_s & req_r;
        base = (q_m[k] | (req_s & ~req_r)) & ~(req_r & ~req_s);
        case (mode_m[k])
          0:       pol = q_m[k];
          1:       pol = 4'b0000;
          2:       pol = 4'b1111;
          default: pol = ~q_m[k];
        endcase
        q_m[k]  = (base & ~both) | (pol & both);
        cf_m[k] = both;
      end
    end
  endtask

  // Apply inputs at the falling edge, advance the model at the rising edge,
  // leave the caller 1 time unit after the edge to sample.
  task automatic drive(input logic rst_v, input logic [3:0] r_v, input logic [3:0] s_v);
    @(negedge clk);
    rst   = rst_v;
    req_r = r_v;
    req_s = s_v;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 4'b0000, 4'b1111);
    drive(1'b1, 4'b0000, 4'b1111);
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (q_o[k] !== rstv_m[k]) begin
        n_fail++; $display("FAIL reset_q[%0d]: got %b want %b", k, q_o[k], rstv_m[k]);
      end
      n_checks++;
      if (qn_o[k] !== ~rstv_m[k]) begin
        n_fail++; $display("FAIL reset_qn[%0d]: got %b want %b", k, qn_o[k], ~rstv_m[k]);
      end
      n_checks++;
      if (cf_o[k] !== 4'b0000) begin
        n_fail++; $display("FAIL reset_conflict[%0d]: got %b want 0000", k, cf_o[k]);
      end
    end
    // Unknown requests during reset must not disturb the reset value.
    drive(1'b1, 4'bxxxx, 4'bxxxx);
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (q_o[k] !== rstv_m[k]) begin
        n_fail++; $display("FAIL reset_x_q[%0d]: got %b want %b", k, q_o[k], rstv_m[k]);
      end
    end
  endtask

  task automatic test_set_clear();
    logic [3:0] want1 [2] = '{4'b0001, 4'b0000};
    drive(1'b0, 4'b0000, 4'b0001);
    n_checks++;
    if (q_o[1] !== want1[0]) begin
      n_fail++; $display("FAIL set_q: got %b want %b", q_o[1], want1[0]);
    end
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (q_o[k] !== q_m[k]) begin
        n_fail++; $display("FAIL set_model_q[%0d]: got %b want %b", k, q_o[k], q_m[k]);
      end
    end
    drive(1'b0, 4'b0001, 4'b0000);
    n_checks++;
    if (q_o[1] !== want1[1]) begin
      n_fail++; $display("FAIL clear_q: got %b want %b", q_o[1], want1[1]);
    end
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (q_o[k] !== q_m[k]) begin
        n_fail++; $display("FAIL clear_model_q[%0d]: got %b want %b", k, q_o[k], q_m[k]);
      end
    end
  endtask

  task automatic test_conflict();
    drive(1'b0, 4'b1111, 4'b0000);
    drive(1'b0, 4'b0010, 4'b1111);
    n_checks++;
    if (q_o[1] !== 4'b1101) begin
      n_fail++; $display("FAIL conflict_q: got %b want 1101", q_o[1]);
    end
    n_checks++;
    if (cf_o[1] !== 4'b0010) begin
      n_fail++; $display("FAIL conflict_flag: got %b want 0010", cf_o[1]);
    end
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (q_o[k] !== q_m[k] || cf_o[k] !== cf_m[k]) begin
        n_fail++; $display("FAIL conflict_model[%0d]: got q=%b c=%b want q=%b c=%b",
                           k, q_o[k], cf_o[k], q_m[k], cf_m[k]);
      end
    end
    drive(1'b0, 4'b0000, 4'b0000);
    n_checks++;
    if (q_o[1] !== 4'b1101 || cf_o[1] !== 4'b0000) begin
      n_fail++; $display("FAIL conflict_release: got q=%b c=%b want q=1101 c=0000", q_o[1], cf_o[1]);
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'(i), 4'((17 - i) % 16));
      for (int k = 0; k < NI; k++) begin
        n_checks++;
        if (q_o[k] !== q_m[k] || qn_o[k] !== ~q_m[k] || cf_o[k] !== cf_m[k]) begin
          n_fail++; $display("FAIL sweep[%0d] i=%0d: got q=%b qn=%b c=%b want q=%b qn=%b c=%b",
                             k, i, q_o[k], qn_o[k], cf_o[k], q_m[k], ~q_m[k], cf_m[k]);
        end
      end
    end
  endtask

  task automatic test_policy();
    logic [3:0] want [NI] = '{4'b1010, 4'b0000, 4'b1111, 4'b0101, 4'b0101};
    drive(1'b0, 4'b0101, 4'b1010);
    drive(1'b0, 4'b1111, 4'b1111);
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (q_o[k] !== want[k]) begin
        n_fail++; $display("FAIL policy_q[%0d]: got %b want %b", k, q_o[k], want[k]);
      end
      n_checks++;
      if (cf_o[k] !== 4'b1111) begin
        n_fail++; $display("FAIL policy_conflict[%0d]: got %b want 1111", k, cf_o[k]);
      end
    end
    // A persisting S=R=1 keeps the conflict flag high and toggles again.
    drive(1'b0, 4'b1111, 4'b1111);
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (q_o[k] !== q_m[k] || cf_o[k] !== 4'b1111) begin
        n_fail++; $display("FAIL policy_hold[%0d]: got q=%b c=%b want q=%b c=1111",
                           k, q_o[k], cf_o[k], q_m[k]);
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b0, 4'b0000, 4'b1111);
    drive(1'b1, 4'b0000, 4'b1111);
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (q_o[k] !== rstv_m[k] || cf_o[k] !== 4'b0000) begin
        n_fail++; $display("FAIL mid_reset[%0d]: got q=%b c=%b want q=%b c=0000",
                           k, q_o[k], cf_o[k], rstv_m[k]);
      end
    end
    drive(1'b0, 4'b0000, 4'b1111);
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (q_o[k] !== 4'b1111) begin
        n_fail++; $display("FAIL mid_reset_resume[%0d]: got %b want 1111", k, q_o[k]);
      end
    end
  endtask

  // Inputs (including rst) wiggling between edges must not move outputs.
  task automatic test_between_edges();
    for (int n = 0; n < 8; n++) begin
      drive(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      rst   = 1'b1;
      req_r = 4'($urandom_range(0, 15));
      req_s = 4'($urandom_range(0, 15));
      #2;
      for (int k = 0; k < NI; k++) begin
        n_checks++;
        if (q_o[k] !== q_m[k] || qn_o[k] !== ~q_m[k] || cf_o[k] !== cf_m[k]) begin
          n_fail++; $display("FAIL between_edges[%0d] n=%0d: got q=%b c=%b want q=%b c=%b",
                             k, n, q_o[k], cf_o[k], q_m[k], cf_m[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 15) == 0), 4'($urandom), 4'($urandom));
      for (int k = 0; k < NI; k++) begin
        n_checks++;
        if (q_o[k] !== q_m[k] || qn_o[k] !== ~q_m[k] || cf_o[k] !== cf_m[k]) begin
          n_fail++; $display("FAIL random[%0d] n=%0d: got q=%b qn=%b c=%b want q=%b qn=%b c=%b",
                             k, n, q_o[k], qn_o[k], cf_o[k], q_m[k], ~q_m[k], cf_m[k]);
        end
      end
    end
  endtask

  // The package rule against the model's rule, exhaustively per bit.
  task automatic test_pkg_rule();
    logic want;
    for (int m = 0; m < 4; m++) begin
      for (int v = 0; v < 8; v++) begin
        logic q, s, r;
        {q, s, r} = 3'(v);
        if (s && r) want = (m == 0) ? q : (m == 1) ? 1'b0 : (m == 2) ? 1'b1 : ~q;
        else        want = s ? 1'b1 : r ? 1'b0 : q;
        n_checks++;
        if (rsff_next(q, s, r, m) !== want) begin
          n_fail++; $display("FAIL pkg_rule mode=%0d q=%b s=%b r=%b: got %b want %b",
                             m, q, s, r, rsff_next(q, s, r, m), want);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      q_m[k]  = rstv_m[k];
      cf_m[k] = 4'b0000;
    end
    test_reset();
    test_set_clear();
    test_conflict();
    test_sweep();
    test_policy();
    test_mid_reset();
    test_between_edges();
    test_random();
    test_pkg_rule();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
